// File: rtl/e_outport_alloc_ctrl_if.sv
// e_outport_alloc_ctrl_if: arbiter, input-queue and crossbar signals of the east output allocator.
interface e_outport_alloc_ctrl_if #(parameter int CNT_W = 3);
    logic [3:0]       grant_i;
    logic [2:0]       grant_cs_i;
    logic [3:0]       flit_valid_i;
    logic [3:0]       flit_tail_i;
    logic             credit_return_i;
    logic [3:0]       pop_o;
    logic [2:0]       xbar_sel_o;
    logic             xbar_valid_o;
    logic             change_order_o;
    logic             downstream_credit_o;
    logic [CNT_W-1:0] credit_cnt_o;
    logic             credit_ovf_o;
    modport master (
        output grant_i, grant_cs_i, flit_valid_i, flit_tail_i, credit_return_i,
        input  pop_o, xbar_sel_o, xbar_valid_o, change_order_o, downstream_credit_o,
               credit_cnt_o, credit_ovf_o
    );
    modport slave (
        input  grant_i, grant_cs_i, flit_valid_i, flit_tail_i, credit_return_i,
        output pop_o, xbar_sel_o, xbar_valid_o, change_order_o, downstream_credit_o,
               credit_cnt_o, credit_ovf_o
    );
endinterface

// File: rtl/e_outport_alloc_ctrl.sv
// e_outport_alloc_ctrl: wormhole lock and downstream credit control for the east output port.
module e_outport_alloc_ctrl #(
    parameter int CREDIT_DEPTH = 4,
    parameter int CNT_W        = 3
) (
    input logic                  clk,
    input logic                  reset,
    e_outport_alloc_ctrl_if.slave p
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t           state;
    logic [3:0]       lock_src;
    logic [2:0]       lock_cs;
    logic [CNT_W-1:0] credit_cnt;
    logic             credit_ovf;
    logic             locked, has_cr, send, tail;
    logic [3:0]       src;
    always_comb begin
        locked = state == LOCKED;
        has_cr = credit_cnt != '0;
        src    = locked ? lock_src : p.grant_i;
        // Reset forces every strobe low even though inputs may still show a grant.
        send   = !reset && has_cr && |(src & p.flit_valid_i);
        tail   = send && |(src & p.flit_tail_i);
    end
    assign p.pop_o               = send ? src : 4'b0;
    assign p.xbar_sel_o          = reset ? 3'b0 : locked ? lock_cs : p.grant_cs_i;
    assign p.xbar_valid_o        = send;
    assign p.change_order_o      = tail;
    assign p.downstream_credit_o = has_cr;
    assign p.credit_cnt_o        = credit_cnt;
    assign p.credit_ovf_o        = credit_ovf;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lock_src   <= '0;
            lock_cs    <= '0;
            credit_cnt <= CNT_W'(CREDIT_DEPTH);
            credit_ovf <= 1'b0;
        end else begin
            if (!locked && send && !tail) begin
                state    <= LOCKED;
                lock_src <= p.grant_i;
                lock_cs  <= p.grant_cs_i;
            end else if (locked && tail) begin
                state <= IDLE;
            end
            if (send && !p.credit_return_i)
                credit_cnt <= credit_cnt - CNT_W'(1);
            else if (!send && p.credit_return_i) begin
                if (credit_cnt == CNT_W'(CREDIT_DEPTH))
                    credit_ovf <= 1'b1;
                else
                    credit_cnt <= credit_cnt + CNT_W'(1);
            end
        end
    end
    a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(p.grant_i));
endmodule

// File: tb/tb_e_outport_alloc_ctrl.sv
// tb_e_outport_alloc_ctrl: directed scenarios plus random traffic against a packet-level model.
module tb_e_outport_alloc_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    e_outport_alloc_ctrl_if #(.CNT_W(3)) bus ();
    e_outport_alloc_ctrl #(.CREDIT_DEPTH(4), .CNT_W(3)) dut (.clk(clk), .reset(reset), .p(bus));
    always #5 clk = ~clk;

    // Model: which input owns the port (-1 = free), its crossbar code, credits left, overflow flag.
    int         owner = -1;
    logic [2:0] owner_cs = '0;
    int         credits = 4;
    bit         ovf = 0;
    logic [3:0] obs_pop;
    logic [2:0] obs_sel;
    logic       obs_xv, obs_co, obs_dc, obs_ovf;
    logic [2:0] obs_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic cycle(input logic [3:0] g, input logic [2:0] c, input logic [3:0] v,
                         input logic [3:0] t, input logic r);
        int s;
        bit snd, tl;
        bus.grant_i = g;
        bus.grant_cs_i = c;
        bus.flit_valid_i = v;
        bus.flit_tail_i = t;
        bus.credit_return_i = r;
        @(negedge clk);
        s = (owner >= 0) ? owner : idx(g);
        snd = s >= 0 && credits > 0 && v[s];
        tl = snd && t[s];
        obs_pop = bus.pop_o; obs_sel = bus.xbar_sel_o; obs_xv = bus.xbar_valid_o;
        obs_co = bus.change_order_o; obs_dc = bus.downstream_credit_o;
        obs_cnt = bus.credit_cnt_o; obs_ovf = bus.credit_ovf_o;
        chk("pop", 32'(obs_pop), snd ? 32'(1 << s) : 32'd0);
        chk("xbar_sel", 32'(obs_sel), 32'((owner >= 0) ? owner_cs : c));
        chk("xbar_valid", 32'(obs_xv), 32'(snd));
        chk("change_order", 32'(obs_co), 32'(tl));
        chk("downstream_credit", 32'(obs_dc), 32'(credits > 0));
        chk("credit_cnt", 32'(obs_cnt), 32'(credits));
        chk("credit_ovf", 32'(obs_ovf), 32'(ovf));
        @(posedge clk);
        if (snd && owner < 0 && !tl) begin owner = s; owner_cs = c; end
        else if (tl) owner = -1;
        if (snd && !r) credits--;
        else if (!snd && r) begin
            if (credits == 4) ovf = 1; else credits++;
        end
        #1;
    endtask

    // Asserts reset mid-cycle with a live grant on the inputs; outputs must collapse at once.
    task automatic do_reset();
        bus.grant_i = 4'b1000; bus.grant_cs_i = 3'b101; bus.flit_valid_i = 4'b1000;
        bus.flit_tail_i = 4'b1000; bus.credit_return_i = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("rst_pop", 32'(bus.pop_o), 32'd0);
        chk("rst_xbar_valid", 32'(bus.xbar_valid_o), 32'd0);
        chk("rst_change_order", 32'(bus.change_order_o), 32'd0);
        chk("rst_xbar_sel", 32'(bus.xbar_sel_o), 32'd0);
        chk("rst_downstream_credit", 32'(bus.downstream_credit_o), 32'd1);
        chk("rst_credit_cnt", 32'(bus.credit_cnt_o), 32'd4);
        chk("rst_credit_ovf", 32'(bus.credit_ovf_o), 32'd0);
        owner = -1; owner_cs = '0; credits = 4; ovf = 0;
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [3:0] g, t;
        bus.grant_i = '0; bus.grant_cs_i = '0; bus.flit_valid_i = '0;
        bus.flit_tail_i = '0; bus.credit_return_i = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        // Single-flit packet from N
        cycle(4'b1000, 3'b000, 4'b1000, 4'b1000, 1'b0);
        chk("t2_pop", 32'(obs_pop), 32'b1000);
        chk("t2_xbar_valid", 32'(obs_xv), 32'd1);
        chk("t2_change_order", 32'(obs_co), 32'd1);
        cycle(4'b0000, 3'b000, 4'b0000, 4'b0000, 1'b0);
        chk("t2_cnt", 32'(obs_cnt), 32'd3);
        // Three-flit packet from W; a competing grant from S is ignored while locked
        cycle(4'b0010, 3'b010, 4'b0010, 4'b0000, 1'b0);
        chk("t3_head_pop", 32'(obs_pop), 32'b0010);
        chk("t3_head_co", 32'(obs_co), 32'd0);
        cycle(4'b0100, 3'b011, 4'b0110, 4'b0000, 1'b0);
        chk("t3_body_pop", 32'(obs_pop), 32'b0010);
        chk("t3_body_sel", 32'(obs_sel), 32'b010);
        cycle(4'b0000, 3'b000, 4'b0010, 4'b0010, 1'b0);
        chk("t3_tail_pop", 32'(obs_pop), 32'b0010);
        chk("t3_tail_co", 32'(obs_co), 32'd1);
        do_reset();
        // Six-flit packet from S runs out of credits after four flits
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(i == 0 ? 4'b0100 : 4'b0000, 3'b001, 4'b0100, 4'b0000, 1'b0);
            if (obs_pop != 0) n++;
        end
        chk("t4_flits", 32'(n), 32'd4);
        chk("t4_cnt", 32'(obs_cnt), 32'd0);
        chk("t4_dc", 32'(obs_dc), 32'd0);
        cycle(4'b0000, 3'b000, 4'b0100, 4'b0000, 1'b1);
        chk("t4_ret_pop", 32'(obs_pop), 32'd0);
        cycle(4'b0000, 3'b000, 4'b0100, 4'b0000, 1'b0);
        chk("t4_one_pop", 32'(obs_pop), 32'b0100);
        cycle(4'b0000, 3'b000, 4'b0100, 4'b0000, 1'b0);
        chk("t4_stall_pop", 32'(obs_pop), 32'd0);
        cycle(4'b0000, 3'b000, 4'b0100, 4'b0000, 1'b1);
        cycle(4'b0000, 3'b000, 4'b0100, 4'b0100, 1'b0);
        chk("t4_tail_co", 32'(obs_co), 32'd1);
        do_reset();
        // Send and return together leave the count unchanged; return at full sets overflow
        cycle(4'b0001, 3'b100, 4'b0001, 4'b0001, 1'b0);
        cycle(4'b0001, 3'b100, 4'b0001, 4'b0001, 1'b0);
        cycle(4'b0001, 3'b100, 4'b0001, 4'b0001, 1'b1);
        chk("t5_cnt_before", 32'(obs_cnt), 32'd2);
        cycle(4'b0000, 3'b000, 4'b0000, 4'b0000, 1'b1);
        chk("t5_cnt_both", 32'(obs_cnt), 32'd2);
        cycle(4'b0000, 3'b000, 4'b0000, 4'b0000, 1'b1);
        cycle(4'b0000, 3'b000, 4'b0000, 4'b0000, 1'b1);
        chk("t5_cnt_full", 32'(obs_cnt), 32'd4);
        cycle(4'b0000, 3'b000, 4'b0000, 4'b0000, 1'b0);
        chk("t5_ovf", 32'(obs_ovf), 32'd1);
        chk("t5_cnt_sat", 32'(obs_cnt), 32'd4);
        cycle(4'b1000, 3'b000, 4'b1000, 4'b1000, 1'b0);
        chk("t5_ovf_sticky", 32'(obs_ovf), 32'd1);
        // Reset in the middle of a five-flit packet from L
        cycle(4'b0001, 3'b100, 4'b0001, 4'b0000, 1'b0);
        cycle(4'b0000, 3'b000, 4'b0001, 4'b0000, 1'b0);
        do_reset();
        cycle(4'b1000, 3'b011, 4'b1001, 4'b1000, 1'b0);
        chk("t6_pop", 32'(obs_pop), 32'b1000);
        chk("t6_sel", 32'(obs_sel), 32'b011);
        chk("t6_cnt", 32'(obs_cnt), 32'd4);
        chk("t6_ovf", 32'(obs_ovf), 32'd0);
        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(299) == 0) do_reset();
            g = ($urandom_range(9) < 7) ? 4'(1 << $urandom_range(3)) : 4'b0000;
            t = '0;
            for (int b = 0; b < 4; b++) t[b] = $urandom_range(3) == 0;
            cycle(g, 3'($urandom_range(7)), 4'($urandom_range(15)), t, 1'($urandom_range(9) < 4));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
